// File: rtl/aes_pkg.sv
// Shared AES key-schedule types, per-length constants, xtime and the S-box table.
package aes_pkg;

    typedef enum logic [1:0] {
        KEY_128  = 2'b00,
        KEY_192  = 2'b01,
        KEY_256  = 2'b10,
        KEY_RSVD = 2'b11
    } key_len_e;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        EXPAND = 2'b01,
        DONE   = 2'b10
    } ks_state_e;

    localparam int unsigned NK_128 = 4;
    localparam int unsigned NK_192 = 6;
    localparam int unsigned NK_256 = 8;
    localparam int unsigned NR_128 = 10;
    localparam int unsigned NR_192 = 12;
    localparam int unsigned NR_256 = 14;
    localparam int unsigned TW_128 = 44;
    localparam int unsigned TW_192 = 52;
    localparam int unsigned TW_256 = 60;

    function automatic logic [3:0] nk_of(input logic [1:0] len);
        case (len)
            KEY_192: return 4'(NK_192);
            KEY_256: return 4'(NK_256);
            default: return 4'(NK_128);
        endcase
    endfunction

    function automatic logic [3:0] nr_of(input logic [1:0] len);
        case (len)
            KEY_192: return 4'(NR_192);
            KEY_256: return 4'(NR_256);
            default: return 4'(NR_128);
        endcase
    endfunction

    function automatic logic [5:0] tw_of(input logic [1:0] len);
        case (len)
            KEY_192: return 6'(TW_192);
            KEY_256: return 6'(TW_256);
            default: return 6'(TW_128);
        endcase
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES S-box byte substitution.
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] data,
    output logic [7:0] sub_c
);

    assign sub_c = SBOX[data];

endmodule

// File: rtl/aes_key_schedule.sv
// Sequential AES key schedule: loads a key, expands one 32-bit word per cycle, serves round keys.
// AES_KEYSCHED_WIDE_KEY_EN enables AES-192/256; without it only AES-128 keys are accepted.
module aes_key_schedule
    import aes_pkg::*;
#(
    parameter int unsigned MAX_KEY_BITS = 256
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start_valid,
    output logic                    start_ready,
    input  logic [1:0]              keyLen,
    input  logic [MAX_KEY_BITS-1:0] cipherKey,
    output logic                    busy,
    output logic                    done,
    output logic                    keyErr,
    output logic                    keyValid,
    output logic [3:0]              nr,
    input  logic [3:0]              rdRound,
    output logic [127:0]            rdKey
);

`ifdef AES_KEYSCHED_WIDE_KEY_EN
    localparam int unsigned NUM_WORDS  = 4 * (MAX_KEY_BITS / 32 + 7);
    localparam int unsigned LOAD_WORDS = (MAX_KEY_BITS / 32 > 8) ? 8 : MAX_KEY_BITS / 32;
`else
    localparam int unsigned NUM_WORDS  = TW_128;
    localparam int unsigned LOAD_WORDS = NK_128;
`endif
    localparam int unsigned IDX_W = $clog2(NUM_WORDS);

    ks_state_e        state_q, state_d;
    logic             accept_c, legal_c, load_c, last_c;
    logic [3:0]       nk_c;
    logic [IDX_W-1:0] i_q, tw_q, rd_base;
    logic [2:0]       imod_q;
    logic [3:0]       nk_q;
    logic [7:0]       rcon_q;
    logic [31:0]      w_mem [NUM_WORDS];
    logic [31:0]      prev_w, back_w, sub_in, temp_w, new_w;
    wire  [31:0]      sub_w;

    // Key-length decode and legality for the current build
    always_comb begin
        nk_c = nk_of(keyLen);
`ifdef AES_KEYSCHED_WIDE_KEY_EN
        legal_c = (keyLen != KEY_RSVD) && (32'(nk_c) * 32 <= MAX_KEY_BITS);
`else
        legal_c = (keyLen == KEY_128);
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        load_c   = 1'b0;
        accept_c = start_valid && start_ready;
        last_c   = (i_q == tw_q - IDX_W'(1));
        case (state_q)
            IDLE: begin
                if (accept_c && legal_c) begin
                    load_c  = 1'b1;
                    state_d = EXPAND;
                end
            end
            EXPAND:  if (last_c) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Status outputs registered from the next state so they line up with the state they describe
    always_ff @(posedge clk) begin
        if (rst) begin
            start_ready <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b0;
            keyErr      <= 1'b0;
            keyValid    <= 1'b0;
            nr          <= 4'd0;
        end else begin
            start_ready <= (state_d == IDLE);
            busy        <= (state_d == EXPAND);
            done        <= (state_d == DONE);
            keyErr      <= accept_c && !legal_c;
            if (state_d == DONE) keyValid <= 1'b1;
            else if (load_c)     keyValid <= 1'b0;
            if (load_c) nr <= nr_of(keyLen);
        end
    end

    // Word index, i mod Nk wrap counter and round constant
    always_ff @(posedge clk) begin
        if (rst) begin
            i_q    <= '0;
            imod_q <= 3'd0;
            nk_q   <= 4'(NK_128);
            tw_q   <= IDX_W'(TW_128);
            rcon_q <= 8'h01;
        end else if (load_c) begin
            i_q    <= IDX_W'(nk_c);
            imod_q <= 3'd0;
            nk_q   <= nk_c;
            tw_q   <= IDX_W'(tw_of(keyLen));
            rcon_q <= 8'h01;
        end else if (state_q == EXPAND) begin
            i_q    <= i_q + IDX_W'(1);
            imod_q <= (imod_q == 3'(nk_q - 4'd1)) ? 3'd0 : imod_q + 3'd1;
            if (imod_q == 3'd0) rcon_q <= xtime(rcon_q);
        end
    end

    always_comb begin
        prev_w = w_mem[i_q - IDX_W'(1)];
        back_w = w_mem[i_q - IDX_W'(nk_q)];
        sub_in = (imod_q == 3'd0) ? {prev_w[23:0], prev_w[31:24]} : prev_w;
    end

    for (genvar b = 0; b < 4; b++) begin : g_subword
        aes_sbox u_sbox (
            .data  (sub_in[8*b +: 8]),
            .sub_c (sub_w[8*b +: 8])
        );
    end

    always_comb begin
        temp_w = prev_w;
        if (imod_q == 3'd0)                         temp_w = sub_w ^ {rcon_q, 24'h0};
        else if (nk_q == 4'd8 && imod_q == 3'd4)    temp_w = sub_w;
        new_w = back_w ^ temp_w;
    end

    // Single write port: key words on load, one expanded word per EXPAND cycle
    always_ff @(posedge clk) begin
        if (load_c) begin
            for (int unsigned j = 0; j < LOAD_WORDS; j++) begin
                if (j < 32'(nk_c))
                    w_mem[IDX_W'(j)] <= 32'(cipherKey >> (MAX_KEY_BITS - 32 * (j + 1)));
            end
        end else if (state_q == EXPAND) begin
            w_mem[i_q] <= new_w;
        end
    end

    assign rd_base = IDX_W'({rdRound, 2'b00});

    always_ff @(posedge clk) begin
        if (rst) rdKey <= '0;
        else     rdKey <= {w_mem[rd_base], w_mem[rd_base + IDX_W'(1)],
                           w_mem[rd_base + IDX_W'(2)], w_mem[rd_base + IDX_W'(3)]};
    end

endmodule

// File: tb/tb_aes_key_schedule.sv
// Self-checking bench for aes_key_schedule: FIPS-197 vectors, rejects, mid-run reset, back-to-back loads.
`timescale 1ns/1ps
module tb_aes_key_schedule;

    localparam logic [255:0] K128    = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [127:0] R1_128  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] R10_128 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
`ifdef AES_KEYSCHED_WIDE_KEY_EN
    localparam logic [255:0] K192    = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
    localparam logic [127:0] R12_192 = 128'he98ba06f448c773c8ecc720401002202;
    localparam logic [255:0] K256    = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    localparam logic [127:0] R1_256  = 128'h1f352c073b6108d72d9810a30914dff4;
    localparam logic [127:0] R14_256 = 128'hfe4890d1e6188d0b046df344706c631e;
`endif

    logic         clk;
    logic         rst;
    logic         start_valid;
    logic         start_ready;
    logic [1:0]   keyLen;
    logic [255:0] cipherKey;
    logic         busy;
    logic         done;
    logic         keyErr;
    logic         keyValid;
    logic [3:0]   nr;
    logic [3:0]   rdRound;
    logic [127:0] rdKey;

    typedef struct packed {
        logic [3:0]   rnd;
        logic [127:0] exp_key;
    } sb_t;

    sb_t sb_q[$];
    int  checks = 0;
    int  errors = 0;

    aes_key_schedule #(.MAX_KEY_BITS(256)) dut (
        .clk         (clk),
        .rst         (rst),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .keyLen      (keyLen),
        .cipherKey   (cipherKey),
        .busy        (busy),
        .done        (done),
        .keyErr      (keyErr),
        .keyValid    (keyValid),
        .nr          (nr),
        .rdRound     (rdRound),
        .rdKey       (rdKey)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values(input string name);
        check({name, "_ready"}, 128'(start_ready), 128'(1));
        check({name, "_busy"},  128'(busy),        128'(0));
        check({name, "_done"},  128'(done),        128'(0));
        check({name, "_err"},   128'(keyErr),      128'(0));
        check({name, "_kv"},    128'(keyValid),    128'(0));
        check({name, "_nr"},    128'(nr),          128'(0));
        check({name, "_rdkey"}, rdKey,             128'(0));
    endtask

    // Read back every queued round and compare against the scoreboard
    task automatic drain(input string name);
        sb_t e;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            rdRound = e.rnd;
            step();
            check($sformatf("%s_round%0d", name, e.rnd), rdKey, e.exp_key);
        end
    endtask

    task automatic wait_done(inout int n);
        while (done !== 1'b1 && n < 200) begin
            step();
            n++;
        end
    endtask

    task automatic load_key(input string name, input logic [1:0] len, input logic [255:0] key,
                            input int lat, input logic [3:0] nr_exp,
                            input logic [3:0] ra, input logic [127:0] ka,
                            input logic [3:0] rb, input logic [127:0] kb);
        int n;
        sb_q.push_back('{rnd: 4'd0, exp_key: key[255:128]});
        sb_q.push_back('{rnd: ra, exp_key: ka});
        sb_q.push_back('{rnd: rb, exp_key: kb});
        start_valid = 1'b1;
        keyLen      = len;
        cipherKey   = key;
        step();
        start_valid = 1'b0;
        n = 1;
        check({name, "_busy_a1"}, 128'(busy), 128'(1));
        check({name, "_kv_a1"}, 128'(keyValid), 128'(0));
        wait_done(n);
        check({name, "_done_latency"}, 128'(n), 128'(lat));
        check({name, "_nr"}, 128'(nr), 128'(nr_exp));
        check({name, "_kv_done"}, 128'(keyValid), 128'(1));
        step();
        check({name, "_done_pulse"}, 128'(done), 128'(0));
        check({name, "_ready_after"}, 128'(start_ready), 128'(1));
        drain(name);
    endtask

    task automatic reject_key(input string name, input logic [1:0] len, input logic kv_exp);
        start_valid = 1'b1;
        keyLen      = len;
        step();
        start_valid = 1'b0;
        check({name, "_err"},   128'(keyErr),      128'(1));
        check({name, "_busy"},  128'(busy),        128'(0));
        check({name, "_kv"},    128'(keyValid),    128'(kv_exp));
        check({name, "_ready"}, 128'(start_ready), 128'(1));
        step();
        check({name, "_err_pulse"}, 128'(keyErr), 128'(0));
        check({name, "_busy2"},     128'(busy),   128'(0));
    endtask

    initial begin
        int n;
        int kv_bad;
        rst         = 1'b1;
        start_valid = 1'b0;
        keyLen      = 2'b00;
        cipherKey   = '0;
        rdRound     = 4'd0;
        step();
        step();
        check_reset_values("reset");
        rst = 1'b0;
        step();

        load_key("aes128", 2'b00, K128, 41, 4'd10, 4'd1, R1_128, 4'd10, R10_128);
        reject_key("rsvd", 2'b11, 1'b1);
`ifdef AES_KEYSCHED_WIDE_KEY_EN
        load_key("aes192", 2'b01, K192, 47, 4'd12, 4'd12, R12_192, 4'd12, R12_192);
        load_key("aes256", 2'b10, K256, 53, 4'd14, 4'd1, R1_256, 4'd14, R14_256);
`else
        reject_key("len192", 2'b01, 1'b1);
        reject_key("len256", 2'b10, 1'b1);
`endif

        // Reset in the middle of an expansion, then reload
        start_valid = 1'b1;
`ifdef AES_KEYSCHED_WIDE_KEY_EN
        keyLen    = 2'b10;
        cipherKey = K256;
`else
        keyLen    = 2'b00;
        cipherKey = K128;
`endif
        step();
        start_valid = 1'b0;
        n = 1;
        while (n < 20) begin
            step();
            n++;
        end
        rst = 1'b1;
        step();
        check_reset_values("midrst");
        rst = 1'b0;
        step();
        check("midrst_no_done", 128'(done), 128'(0));
        load_key("reload128", 2'b00, K128, 41, 4'd10, 4'd1, R1_128, 4'd10, R10_128);

        // Back-to-back loads with start_valid held high throughout
        start_valid = 1'b1;
        keyLen      = 2'b00;
        cipherKey   = '0;
        step();
        n = 1;
        check("b2b_first_busy", 128'(busy), 128'(1));
        wait_done(n);
        check("b2b_first_latency", 128'(n), 128'(41));
        cipherKey = K128;
        sb_q.push_back('{rnd: 4'd0, exp_key: K128[255:128]});
        sb_q.push_back('{rnd: 4'd1, exp_key: R1_128});
        sb_q.push_back('{rnd: 4'd10, exp_key: R10_128});
        step();
        check("b2b_ready_after_done", 128'(start_ready), 128'(1));
        step();
        start_valid = 1'b0;
        n = 1;
        check("b2b_second_busy", 128'(busy), 128'(1));
        check("b2b_second_kv", 128'(keyValid), 128'(0));
        kv_bad = 0;
        while (done !== 1'b1 && n < 200) begin
            if (keyValid !== 1'b0) kv_bad++;
            step();
            n++;
        end
        check("b2b_kv_low_cycles", 128'(kv_bad), 128'(0));
        check("b2b_second_latency", 128'(n), 128'(41));
        step();
        drain("b2b");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/aes_key_schedule.md
# aes_key_schedule

Sequential, parametrised AES key schedule supporting AES-128, AES-192 and AES-256. It loads a cipher key on a valid/ready handshake and generates one 32-bit expanded word per cycle into internal storage. Round keys are then served through a registered read port. It replaces the one-shot combinational 128-bit expander and sits between key-load control and the round datapath, which fetches round keys by index.

## Interface
- MAX_KEY_BITS, 256: widest supported key. Sets the key-port width and storage depth (4*(MAX_KEY_BITS/32+7) words, 60 at 256).
- clk  in  1  single clock; everything is on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- start_valid  in  1  key load request.
- start_ready  out  1  high only in IDLE.
- keyLen  in  2  00=128, 01=192, 10=256, 11 reserved. Sampled at acceptance.
- cipherKey  in  MAX_KEY_BITS  key, MSB-aligned. A 128-bit key uses [255:128] and a 192-bit key uses [255:64]. Sampled at acceptance.
- busy  out  1  expansion in progress.
- done  out  1  one-cycle pulse when the schedule is complete.
- keyErr  out  1  one-cycle pulse when a key load is rejected.
- keyValid  out  1  stored schedule is complete and current.
- nr  out  4  round count of the current schedule: 10, 12 or 14.
- rdRound  in  4  round-key index, 0..nr.
- rdKey  out  128  words w[4r..4r+3], with w[4r] in [127:96].

## Operation
- States: IDLE, EXPAND, DONE.
  - IDLE -> EXPAND on accept (start_valid && start_ready) with a legal keyLen.
  - IDLE -> IDLE on accept with an illegal keyLen: keyErr pulses the next cycle.
  - EXPAND -> DONE after the final word is written.
  - DONE -> IDLE unconditionally.
- Derived constants: Nk = 4/6/8, Nr = 10/12/14, total words T_w = 44/52/60.
- Accept:
  - Write w[0..Nk-1] from cipherKey in one cycle.
  - Set i=Nk, rcon=8'h01, latch nr.
  - Clear keyValid.
- EXPAND, each cycle compute and write w[i], then i++:
  - temp = w[i-1].
  - If i%Nk==0: temp = SubWord(RotWord(temp)) ^ {rcon,24'h0}, then rcon = xtime(rcon) (xtime = shift left 1, XOR 8'h1b if bit 7 was set).
  - Else if Nk==8 and i%Nk==4: temp = SubWord(temp).
  - w[i] = w[i-Nk] ^ temp.
  - i%Nk is tracked with a wrap counter; no divider.
- Last write is at i = T_w-1. Then DONE: done=1, keyValid set.
- rdKey is registered. Reads are permitted anytime; before keyValid the data is undefined but causes no error. rdRound > nr returns undefined data.

## Timing
- Reset values: start_ready=1, busy=0, done=0, keyErr=0, keyValid=0, nr=0, rdKey=0. Storage is not cleared.
- If acceptance occurs in cycle A:
  - busy is high A+1 .. A+T_w-Nk.
  - done and keyValid rise in A+T_w-Nk+1. That is 41, 47 and 53 cycles after accept for AES-128, -192 and -256.
- start_ready returns high the cycle after DONE. A new key may be accepted the cycle after DONE.
- Acceptance clears keyValid in A+1. The old schedule is not readable as valid during re-expansion.
- rdKey latency is 1 cycle from rdRound.
- Reset mid-EXPAND returns to IDLE next cycle with no done pulse and keyValid=0.
- start_valid held while busy has no effect. The request is not queued.

## Configuration
- AES_KEYSCHED_WIDE_KEY_EN.
  - Defined: all three key lengths are supported; storage is 60 words.
  - Undefined: AES-128 only, storage is 44 words, and cipherKey[127:0] is ignored. keyLen 01/10/11 is rejected with a keyErr pulse and no state change.

## Structure
- Package aes_pkg holds:
  - the keyLen encoding typedef;
  - the Nk/Nr/T_w constants per length;
  - the xtime function;
  - the AES S-box table.
- Sub-module aes_sbox: combinational 8-bit S-box lookup. Four instances form SubWord.
- Storage is a register array of 32-bit words, single write port, with a separate read mux feeding the rdKey register.

## Test plan
- AES-128, FIPS-197 key 2b7e1516 28aed2a6 abf71588 09cf4f3c -> round 1 = a0fafe17 88542cb1 23a33939 2a6c7605, round 10 = d014f9a8 c9ee2589 e13f0cc8 b6630ca6, done 41 cycles after accept.
- AES-192, key 8e73b0f7 da0e6452 c810f32b 809079e5 62f8ead2 522c6b7b -> round 12 = e98ba06f 448c773c 8ecc7204 01002202, nr=12, done at +47.
- AES-256, key 603deb10 15ca71be 2b73aef0 857d7781 1f352c07 3b6108d7 2d9810a3 0914dff4 -> round 14 = fe4890d1 e6188d0b 046df344 706c631e, done at +53.
- keyLen=11 with start_valid -> keyErr pulse, busy stays 0, keyValid unchanged. With the macro undefined, keyLen=01 gives the same result.
- rst asserted at cycle 20 of an AES-256 expansion -> all outputs at reset values next cycle. A following AES-128 load then produces correct round 10.
- Back-to-back loads with start_valid held high -> second accept in the cycle after DONE. keyValid drops for the whole second expansion.
